// File: rtl/oled_digit_streamer_if.sv
// ---------------------------------------------------------------------------
// oled_digit_streamer_if
//   Bundles the two handshakes of the OLED digit streamer:
//     digit side : digit[3:0], digit_valid  -> streamer, digit_ready <- streamer
//     byte side  : byte_data[7:0], byte_valid, byte_last <- streamer,
//                  byte_ready -> streamer
//   Modports:
//     master : the environment (offers digits, consumes bytes)
//     slave  : the streamer itself
// ---------------------------------------------------------------------------
interface oled_digit_streamer_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;

    modport master (
        output digit, digit_valid, byte_ready,
        input  digit_ready, byte_data, byte_valid, byte_last
    );

    modport slave (
        input  digit, digit_valid, byte_ready,
        output digit_ready, byte_data, byte_valid, byte_last
    );
endinterface

// File: rtl/oled_digit_streamer.sv
// ---------------------------------------------------------------------------
// oled_digit_streamer
//   Accepts one digit (0..9) and streams a full 128x32 SSD1306 frame of
//   512 page bytes in horizontal-addressing order. The digit glyph (16x16
//   ROM) is drawn scaled 2x into a 32-column window starting at GLYPH_COL.
//   Byte index i: page = i[8:7], column = i[6:0]; bit 0 is the page's top row.
//
//   Parameters:
//     GLYPH_COL : left column of the glyph window, 0..96
//   Ports:
//     clk   : clock, all state on rising edge
//     reset : synchronous, active-high
//     bus   : oled_digit_streamer_if.slave (digit in, page bytes out)
//   Optional build macro:
//     OLED_STREAM_BORDER_EN : ORs a 1-pixel screen border into every byte
// ---------------------------------------------------------------------------
module oled_digit_streamer #(
    parameter int GLYPH_COL = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    oled_digit_streamer_if.slave        bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'd511;
    localparam logic [6:0] WIN_LO   = 7'(GLYPH_COL);

    state_t     state_q, state_d;
    logic [8:0] idx_q,   idx_d;
    logic [3:0] digit_q, digit_d;

    logic       digit_ready_o;
    logic       byte_valid_o;
    logic       byte_last_o;
    logic [7:0] byte_data_o;

    // -----------------------------------------------------------------------
    // Glyph ROM. Every digit is built from five horizontal bands so that the
    // table stays readable:
    //   rows 2-3 top bar, rows 4-6 upper sides, rows 7-8 middle,
    //   rows 9-11 lower sides, rows 12-13 bottom bar; rows 0,1,14,15 blank.
    // Bit 15 is the leftmost column. Codes 10..15 yield a blank glyph.
    // -----------------------------------------------------------------------
    function automatic logic [15:0] glyph_row(input logic [3:0] d, input logic [3:0] r);
        logic [15:0] top, up, mid, low, bot;
        logic [15:0] row;
        top = 16'h0000;
        up  = 16'h0000;
        mid = 16'h0000;
        low = 16'h0000;
        bot = 16'h0000;
        case (d)
            4'd0: begin top = 16'h0FF0; up = 16'h0C30; mid = 16'h0C30; low = 16'h0C30; bot = 16'h0FF0; end
            // digit 1 is a plain two-column stroke through rows 2..13
            4'd1: begin top = 16'h0180; up = 16'h0180; mid = 16'h0180; low = 16'h0180; bot = 16'h0180; end
            4'd2: begin top = 16'h0FF0; up = 16'h0030; mid = 16'h0FF0; low = 16'h0C00; bot = 16'h0FF0; end
            4'd3: begin top = 16'h0FF0; up = 16'h0030; mid = 16'h0FF0; low = 16'h0030; bot = 16'h0FF0; end
            4'd4: begin top = 16'h0000; up = 16'h0C30; mid = 16'h0FF0; low = 16'h0030; bot = 16'h0000; end
            4'd5: begin top = 16'h0FF0; up = 16'h0C00; mid = 16'h0FF0; low = 16'h0030; bot = 16'h0FF0; end
            4'd6: begin top = 16'h0FF0; up = 16'h0C00; mid = 16'h0FF0; low = 16'h0C30; bot = 16'h0FF0; end
            4'd7: begin top = 16'h0FF0; up = 16'h0030; mid = 16'h0030; low = 16'h0030; bot = 16'h0000; end
            4'd8: begin top = 16'h0FF0; up = 16'h0C30; mid = 16'h0FF0; low = 16'h0C30; bot = 16'h0FF0; end
            4'd9: begin top = 16'h0FF0; up = 16'h0C30; mid = 16'h0FF0; low = 16'h0030; bot = 16'h0FF0; end
            default: ;
        endcase
        case (r)
            4'd2,  4'd3:         row = top;
            4'd4,  4'd5,  4'd6:  row = up;
            4'd7,  4'd8:         row = mid;
            4'd9,  4'd10, 4'd11: row = low;
            4'd12, 4'd13:        row = bot;
            default:             row = 16'h0000;
        endcase
        return row;
    endfunction

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 9'd0;
            digit_q <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        digit_d       = digit_q;
        digit_ready_o = 1'b0;
        byte_valid_o  = 1'b0;
        byte_last_o   = 1'b0;
        case (state_q)
            IDLE: begin
                digit_ready_o = 1'b1;
                if (bus.digit_valid) begin
                    digit_d = bus.digit;
                    idx_d   = 9'd0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // digit_valid is deliberately not looked at here: the
                // latched digit must stay fixed for the whole frame
                byte_valid_o = 1'b1;
                byte_last_o  = (idx_q == LAST_IDX);
                if (bus.byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 9'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pixel generation. The byte is a pure function of (idx_q, digit_q), so
    // it holds by construction while the consumer stalls.
    // -----------------------------------------------------------------------
    logic [1:0] page;
    logic [6:0] col;
    logic [6:0] col_off;
    logic [3:0] glyph_col;
    logic       in_window;
    logic [7:0] glyph_bits;
    logic [7:0] pixel_byte;

    assign page      = idx_q[8:7];
    assign col       = idx_q[6:0];
    // Left of the window the subtraction wraps to >= 32 (WIN_LO <= 96), and
    // right of it the offset is >= 32 without wrapping (WIN_LO + 31 <= 127),
    // so a single compare bounds both sides.
    assign col_off   = col - WIN_LO;
    assign in_window = (col_off < 7'd32);
    assign glyph_col = col_off[4:1];

    // Byte bits 2gi and 2gi+1 both come from glyph row page*4 + gi (2x vertical)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row_pair
            logic [15:0] rom_row;
            logic        pix;
            assign rom_row = glyph_row(digit_q, {page, 2'(gi)});
            assign pix     = rom_row[4'd15 - glyph_col];
            assign glyph_bits[2*gi]   = pix;
            assign glyph_bits[2*gi+1] = pix;
        end
    endgenerate

`ifdef OLED_STREAM_BORDER_EN
    logic [7:0] border_bits;
    always_comb begin
        border_bits = 8'h00;
        if (col == 7'd0 || col == 7'd127) begin
            border_bits = 8'hFF;
        end
        if (page == 2'd0) begin
            border_bits = border_bits | 8'h01;
        end
        if (page == 2'd3) begin
            border_bits = border_bits | 8'h80;
        end
    end
    assign pixel_byte = (in_window ? glyph_bits : 8'h00) | border_bits;
`else
    assign pixel_byte = in_window ? glyph_bits : 8'h00;
`endif

    // Outside a frame the data bus is parked at zero
    assign byte_data_o = (state_q == STREAM) ? pixel_byte : 8'h00;

    assign bus.digit_ready = digit_ready_o;
    assign bus.byte_valid  = byte_valid_o;
    assign bus.byte_last   = byte_last_o;
    assign bus.byte_data   = byte_data_o;

endmodule

// File: tb/tb_oled_digit_streamer.sv
module tb_oled_digit_streamer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       digit_valid = 1'b0;
    logic       byte_ready = 1'b1;

    always #5 clk = ~clk;

    oled_digit_streamer_if if0 ();
    oled_digit_streamer_if if96 ();

    assign if0.digit        = digit;
    assign if0.digit_valid  = digit_valid;
    assign if0.byte_ready   = byte_ready;
    assign if96.digit       = digit;
    assign if96.digit_valid = digit_valid;
    assign if96.byte_ready  = byte_ready;

    oled_digit_streamer #(.GLYPH_COL(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    oled_digit_streamer #(.GLYPH_COL(96)) u_dut96 (
        .clk   (clk),
        .reset (reset),
        .bus   (if96)
    );

    int checks = 0;
    int errors = 0;

    // Reference glyph bitmaps (row 0 top, bit 15 leftmost), only the digits
    // the stimulus uses; everything else is blank.
    logic [15:0] ref_rom [16][16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected page byte for frame index i of digit d with window at gc
    function automatic int exp_byte(input int i, input int d, input int gc);
        int p, c, b, row, gcl;
        p = i / 128;
        c = i % 128;
        b = 0;
        if (c >= gc && c < gc + 32) begin
            for (int k = 0; k < 8; k++) begin
                row = (p * 8 + k) / 2;
                gcl = (c - gc) / 2;
                if (ref_rom[d][row][15 - gcl]) b = b | (1 << k);
            end
        end
`ifdef OLED_STREAM_BORDER_EN
        if (c == 0 || c == 127) b = b | 8'hFF;
        if (p == 0) b = b | 8'h01;
        if (p == 3) b = b | 8'h80;
`endif
        return b;
    endfunction

    // ---------------- transaction-level model ----------------
    logic m_en = 1'b0;
    logic m_stream = 1'b0;
    logic m_just_rst = 1'b0;
    int   m_idx = 0;
    int   m_digit = 0;

    always @(posedge clk) begin
        m_just_rst <= 1'b0;
        if (reset) begin
            m_en       <= 1'b1;
            m_stream   <= 1'b0;
            m_idx      <= 0;
            m_digit    <= 0;
            m_just_rst <= 1'b1;
        end else if (!m_stream) begin
            if (digit_valid) begin
                m_stream <= 1'b1;
                m_idx    <= 0;
                m_digit  <= int'(digit);
                $display("accept digit %0d at %0t", digit, $time);
            end
        end else if (byte_ready) begin
            if (m_idx == 511) begin
                m_stream <= 1'b0;
                m_idx    <= 0;
                $display("frame done digit %0d at %0t", m_digit, $time);
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    task automatic compare_dut(input string tag, input int gc, input logic dr, input logic bv,
                               input logic bl, input logic [7:0] bd);
        check({tag, " digit_ready"}, int'(dr), int'(!m_stream));
        check({tag, " byte_valid"}, int'(bv), int'(m_stream));
        check({tag, " byte_last"}, int'(bl), int'(m_stream && m_idx == 511));
        if (m_stream)
            check($sformatf("%s byte_data[%0d]", tag, m_idx), int'(bd), exp_byte(m_idx, m_digit, gc));
        if (m_just_rst)
            check({tag, " byte_data after reset"}, int'(bd), 0);
    endtask

    // Hand-computed literals that pin the model itself
    task automatic pin_literals();
        if (m_stream && m_digit == 1) begin
            case (m_idx)
                13:       check("lit d1 col0 byte13", int'(if0.byte_data), 8'h00);
                14, 15:   check($sformatf("lit d1 col0 byte%0d", m_idx), int'(if0.byte_data), 8'hF0);
                142, 270: check($sformatf("lit d1 col0 byte%0d", m_idx), int'(if0.byte_data), 8'hFF);
                398:      check("lit d1 col0 byte398", int'(if0.byte_data), 8'h0F);
                default: ;
            endcase
            case (m_idx)
                110, 111: check($sformatf("lit d1 col96 byte%0d", m_idx), int'(if96.byte_data), 8'hF0);
`ifdef OLED_STREAM_BORDER_EN
                127:      check("lit d1 col96 byte127", int'(if96.byte_data), 8'hFF);
`else
                127:      check("lit d1 col96 byte127", int'(if96.byte_data), 8'h00);
`endif
                default: ;
            endcase
        end
        if (m_stream && m_digit == 12) begin
`ifdef OLED_STREAM_BORDER_EN
            case (m_idx)
                0, 511: check($sformatf("lit d12 border byte%0d", m_idx), int'(if0.byte_data), 8'hFF);
                1:      check("lit d12 border byte1", int'(if0.byte_data), 8'h01);
                385:    check("lit d12 border byte385", int'(if0.byte_data), 8'h80);
                default: ;
            endcase
`else
            check($sformatf("lit d12 blank byte%0d", m_idx), int'(if0.byte_data), 8'h00);
`endif
        end
    endtask

    always @(negedge clk) begin
        if (m_en) begin
            compare_dut("col0", 0, if0.digit_ready, if0.byte_valid, if0.byte_last, if0.byte_data);
            compare_dut("col96", 96, if96.digit_ready, if96.byte_valid, if96.byte_last, if96.byte_data);
            pin_literals();
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_digit(input logic [3:0] d);
        digit = d;
        digit_valid = 1'b1;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        check("handshake accepted", int'(m_stream), 1);
    endtask

    // rnd: toggle byte_ready randomly; pulse_at >= 0 offers digit 7 mid-frame
    task automatic run_frame(input bit rnd, input int pulse_at);
        int n;
        n = 0;
        while (m_stream && n < 4000) begin
            @(posedge clk);
            #1;
            if (rnd) byte_ready = 1'($urandom_range(0, 1));
            if (pulse_at >= 0 && n == pulse_at) begin
                digit = 4'd7;
                digit_valid = 1'b1;
            end
            if (pulse_at >= 0 && n == pulse_at + 3) digit_valid = 1'b0;
            n++;
        end
        digit_valid = 1'b0;
        byte_ready = 1'b1;
        if (m_stream) begin
            errors++;
            $display("FAIL frame timeout: still streaming after %0d cycles", n);
        end
        checks++;
    endtask

    task automatic reset_at(input int target);
        int n;
        n = 0;
        while (!(m_stream && m_idx == target) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL reset_at timeout: index %0d never reached", target);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset asserted at byte %0d", target);
    endtask

    initial begin
        for (int d = 0; d < 16; d++)
            for (int r = 0; r < 16; r++)
                ref_rom[d][r] = 16'h0000;
        for (int r = 2; r <= 13; r++) ref_rom[1][r] = 16'h0180;
        ref_rom[7] = '{16'h0000, 16'h0000, 16'h0FF0, 16'h0FF0, 16'h0030, 16'h0030, 16'h0030, 16'h0030,
                       16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        ref_rom[8] = '{16'h0000, 16'h0000, 16'h0FF0, 16'h0FF0, 16'h0C30, 16'h0C30, 16'h0C30, 16'h0FF0,
                       16'h0FF0, 16'h0C30, 16'h0C30, 16'h0C30, 16'h0FF0, 16'h0FF0, 16'h0000, 16'h0000};

        // Reset wins over a simultaneous digit offer
        reset = 1'b1;
        digit = 4'd5;
        digit_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        digit_valid = 1'b0;
        @(posedge clk);
        #1;

        send_digit(4'd1);           // continuous ready, digit 1 reference
        run_frame(1'b0, -1);
        @(posedge clk); #1;

        send_digit(4'd12);          // out-of-range code -> blank glyph
        run_frame(1'b0, -1);
        @(posedge clk); #1;

        send_digit(4'd1);           // random stalls + digit 7 offered mid-frame
        run_frame(1'b1, 50);
        repeat (3) @(posedge clk);
        #1;
        check("idle without new handshake", int'(m_stream), 0);

        send_digit(4'd7);           // digit 7 only on a fresh handshake
        run_frame(1'b0, -1);
        @(posedge clk); #1;

        send_digit(4'd8);           // abandoned by reset at byte 200
        reset_at(200);
        @(posedge clk); #1;

        send_digit(4'd1);           // next frame restarts from byte 0
        run_frame(1'b0, -1);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oled_digit_streamer.md
OLED_DIGIT_STREAMER -- requirements
Module: oled_digit_streamer

Interface
REQ-001 SHALL have parameter GLYPH_COL, default 0, meaning the left display column of the 32-column glyph window; legal values 0..96.
REQ-002 SHALL have port clk  input  1  clock; the block uses this one clock, and every register updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; reset is synchronous and active-high.
REQ-004 SHALL have port digit  input  4  class index to render, legal values 0..9.
REQ-005 SHALL have port digit_valid  input  1  digit is offered.
REQ-006 SHALL have port digit_ready  output  1  block can accept a digit.
REQ-007 SHALL have port byte_data  output  8  page byte in SSD1306 horizontal-addressing order; bit 0 is the top row of the page.
REQ-008 SHALL have port byte_valid  output  1  byte_data is valid.
REQ-009 SHALL have port byte_ready  input  1  the downstream OLED serializer consumes the byte.
REQ-010 SHALL have port byte_last  output  1  marks byte 511 of the frame.

Function
REQ-011 SHALL implement two states: IDLE, which drives digit_ready=1 and byte_valid=0, and STREAM, which drives digit_ready=0.
REQ-012 SHALL, in IDLE, on digit_valid&&digit_ready, latch digit, clear the byte index to 0 and enter STREAM; byte 0 SHALL appear with byte_valid=1 on the next cycle.
REQ-013 SHALL produce a frame of 512 bytes, index i=0..511, where page p=i[8:7] and column c=i[6:0].
REQ-014 SHALL hold byte_data, byte_valid and byte_last stable while byte_valid&&!byte_ready.
REQ-015 SHALL advance i by 1 on each byte_valid&&byte_ready and SHALL present the next byte on the following cycle, sustaining 1 byte/cycle under continuous ready.
REQ-016 SHALL assert byte_last only with i=511; acceptance of byte 511 SHALL return to IDLE, with byte_valid=0 and digit_ready=1 on the next cycle.
REQ-017 SHALL ignore digit_valid during STREAM; the latched digit SHALL NOT change mid-frame.
REQ-018 SHALL read each glyph from a combinational ROM of 10 glyphs x 16 rows x 16 bits; row 0 is the top row and bit 15 is the leftmost column.
REQ-019 SHALL define ROM rows 0 and 15 as zero for every digit; digit 1 SHALL be columns 7..8 set in rows 2..13 and all other bits 0.
REQ-020 SHALL render each glyph scaled 2x in both axes, covering columns GLYPH_COL..GLYPH_COL+31 and all 4 pages.
REQ-021 SHALL, inside the glyph window, set bit k of byte (p,c) equal to ROM[row (p*8+k)/2][column (c-GLYPH_COL)/2].
REQ-022 SHALL set every glyph bit outside the glyph window to 0.
REQ-023 SHALL render latched digit values 10..15 as an all-zero glyph.
REQ-024 SHALL compute the column and row offsets so they do not wrap; GLYPH_COL+31 never exceeds 127.

Reset
REQ-025 SHALL, on reset, drive state=IDLE, i=0, latched digit=0, byte_valid=0, byte_last=0, byte_data=0x00 and digit_ready=1 on the next cycle.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame, emit no further bytes and require a new digit handshake before streaming again.
REQ-027 SHALL keep reset priority over every simultaneous handshake.

Configuration
REQ-028 SHALL, with macro OLED_STREAM_BORDER_EN defined, OR a 1-pixel screen frame into every byte as follows:
- columns 0 and 127 of every page: 0xFF;
- page 0 of every column: bit 0 set;
- page 3 of every column: bit 7 set.
REQ-029 SHALL, without OLED_STREAM_BORDER_EN, contain no border logic, so that bytes come only from the glyph.

Verification
REQ-030 SHALL cover this case: reset, then digit=1 with GLYPH_COL=0 and byte_ready held 1 -> byte_valid rises the cycle after acceptance, followed by 512 consecutive bytes with these values:
- bytes 14 and 15: 0xF0;
- bytes 142 and 270: 0xFF;
- byte 398: 0x0F;
- byte 13: 0x00;
- byte_last set on byte 511 only.
REQ-031 SHALL cover this case: digit=12 -> all 512 bytes 0x00 (border macro off); with OLED_STREAM_BORDER_EN the same stimulus -> byte 0 = 0xFF, byte 1 = 0x01, byte 385 = 0x80, byte 511 = 0xFF.
REQ-032 SHALL cover this case: byte_ready toggled at random -> byte_data stays stable while stalled, no byte is skipped or duplicated, and the sequence equals the REQ-030 reference.
REQ-033 SHALL cover this case: digit_valid pulsed with digit=7 during the frame for digit 1 -> digit_ready=0 and the output still matches digit 1; after the last byte digit_ready=1, and digit 7 is accepted only on a new handshake.
REQ-034 SHALL cover this case: reset at byte 200 -> byte_valid=0 on the next cycle and the following frame starts at byte 0.
REQ-035 SHALL cover this case: GLYPH_COL=96 with digit 1 -> bytes 110 and 111 = 0xF0 and column 127 equals the glyph value only.
